// File: rtl/water_inlet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : water_inlet_arbiter
// Description : Round-robin arbiter for one shared water-mains valve feeding
//               four washers. Grants one washer at a time, limits each fill
//               by a timeout, and keeps a closing gap between grants.
// Revision    : 1.0 - initial release
// ============================================================================
module water_inlet_arbiter #(
    parameter int unsigned FILL_TIMEOUT = 200,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] filled,
    input  logic [3:0] clr_fault,
    output logic [3:0] grant,
    output logic       busy,
    output logic [3:0] fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(FILL_TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST     = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] fault_q, fault_d;
    logic       busy_q, busy_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] gidx_q, gidx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;

    logic [3:0] w_elig;
    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic [1:0] w_probe;
    logic [3:0] w_fault_set;

    assign w_elig = req & ~fault_q;

    // Rotating priority search: lowest offset from rr_ptr wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = rr_ptr_q;
        w_probe      = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            w_probe = rr_ptr_q + 2'(k);
            if (w_elig[w_probe]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_probe;
            end
        end
    end

    // Next-state, grant, counters and fault update.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        w_fault_set = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    state_d = ST_GRANT;
                    grant_d = 4'b0001 << w_pick_idx;
                    gidx_d  = w_pick_idx;
                    cnt_d   = 8'd0;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + 8'd1;
                if (filled[gidx_q] || !req[gidx_q] || (cnt_q == TIMEOUT_LAST)) begin
                    // A fill that completes exactly at the timeout is a normal release.
                    if ((cnt_q == TIMEOUT_LAST) && !filled[gidx_q]) begin
                        w_fault_set[gidx_q] = 1'b1;
                    end
                    state_d  = ST_GAP;
                    grant_d  = 4'b0000;
                    cnt_d    = 8'd0;
                    gap_d    = 4'd0;
                    rr_ptr_d = gidx_q + 2'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    // Arbitrate on the closing edge of the gap so that exactly
                    // GAP_CYCLES idle cycles separate back-to-back grants.
                    if (w_pick_valid) begin
                        state_d = ST_GRANT;
                        grant_d = 4'b0001 << w_pick_idx;
                        gidx_d  = w_pick_idx;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase

        // Timeout set takes priority over a same-edge clear.
        fault_d = (fault_q & ~clr_fault) | w_fault_set;
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 4'b0000;
            fault_q  <= 4'b0000;
            busy_q   <= 1'b0;
            rr_ptr_q <= 2'd0;
            gidx_q   <= 2'd0;
            cnt_q    <= 8'd0;
            gap_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_water_inlet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_water_inlet_arbiter
// Description : Self-checking bench for water_inlet_arbiter: a cycle-level
//               behavioural model checked every cycle, plus directed scenarios
//               with hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_water_inlet_arbiter;

    localparam int FILL_TIMEOUT = 200;
    localparam int GAP          = 2;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic [3:0] req       = 4'b0000;
    logic [3:0] filled    = 4'b0000;
    logic [3:0] clr_fault = 4'b0000;
    logic [3:0] grant;
    logic [3:0] fault;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    water_inlet_arbiter #(
        .FILL_TIMEOUT(FILL_TIMEOUT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .filled   (filled),
        .clr_fault(clr_fault),
        .grant    (grant),
        .busy     (busy),
        .fault    (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: washer currently holding the valve (-1 none)
    // held : cycles the current owner has held the valve
    // quiet: closing-gap cycles still to elapse (0 = free)
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_quiet = 0;
    int         m_rr    = 0;
    logic [3:0] m_fault = 4'b0000;

    task automatic model_step();
        logic [3:0] fnext;
        logic [3:0] elig;
        fnext = m_fault & ~clr_fault;
        if (m_owner >= 0) begin
            m_held = m_held + 1;
            if (filled[m_owner] || !req[m_owner] || (m_held == FILL_TIMEOUT)) begin
                if ((m_held == FILL_TIMEOUT) && !filled[m_owner]) fnext[m_owner] = 1'b1;
                m_rr    = (m_owner + 1) % 4;
                m_owner = -1;
                m_quiet = GAP;
            end
        end else if (m_quiet > 1) begin
            m_quiet = m_quiet - 1;
        end else begin
            m_quiet = 0;
            elig = req & ~m_fault;
            for (int k = 0; k < 4; k++) begin
                if ((m_owner < 0) && elig[(m_rr + k) % 4]) begin
                    m_owner = (m_rr + k) % 4;
                    m_held  = 0;
                end
            end
        end
        m_fault = fnext;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_owner = -1; m_held = 0; m_quiet = 0; m_rr = 0; m_fault = 4'b0000;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        logic [3:0] eg;
        forever begin
            @(posedge clk);
            #1;
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check("model_grant", 32'(grant), 32'(eg));
            check("model_busy",  32'(busy),  32'((m_owner >= 0) || (m_quiet > 0)));
            check("model_fault", 32'(fault), 32'(m_fault));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; req = 4'b0000; filled = 4'b0000; clr_fault = 4'b0000;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic wait_grant(output int idx, output int zeros);
        idx = -1;
        zeros = 0;
        for (int i = 0; i < 60 && grant == 4'b0000; i++) begin
            zeros++;
            tick();
        end
        if (grant == 4'b0000) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_grant: got no grant within 60 cycles, expected a grant");
        end else begin
            for (int b = 0; b < 4; b++) if (grant[b]) idx = b;
        end
    endtask

    initial begin
        int idx, zeros, n, seen;
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset state
        tick(1);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_fault", 32'(fault), 32'h0);

        // Single request, filled 10 cycles after grant
        do_reset();
        req = 4'b0001;
        tick();
        check("single_grant_on", 32'(grant), 32'h1);
        tick(10);
        check("single_grant_held", 32'(grant), 32'h1);
        filled = 4'b0001;
        tick();
        check("single_release", 32'(grant), 32'h0);
        check("single_gap_busy1", 32'(busy), 32'h1);
        req = 4'b0000; filled = 4'b0000;
        tick();
        check("single_gap_grant", 32'(grant), 32'h0);
        check("single_gap_busy2", 32'(busy), 32'h1);
        tick();
        check("single_idle_busy", 32'(busy), 32'h0);
        check("single_no_fault", 32'(fault), 32'h0);

        // Already-filled request: granted, released one cycle later
        do_reset();
        req = 4'b1000; filled = 4'b1000;
        tick();
        check("prefilled_grant", 32'(grant), 32'h8);
        tick();
        check("prefilled_release", 32'(grant), 32'h0);
        req = 4'b0000; filled = 4'b0000;

        // Round-robin with all four requesting
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant(idx, zeros);
            check("rr_order", 32'(idx), 32'(order[j]));
            if (j > 0) check("rr_gap_zeros", 32'(zeros), 32'd2);
            tick(3);
            filled = 4'b0001 << idx[1:0];
            tick();
            filled = 4'b0000;
        end
        req = 4'b0000;

        // Timeout, then faulted index skipped, then cleared
        do_reset();
        req = 4'b0100;
        tick();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (grant == 4'b0000) break;
            n++;
            tick();
        end
        check("timeout_len", 32'(n), 32'd200);
        check("timeout_fault", 32'(fault), 32'h4);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (grant != 4'b0000) seen = 1;
            tick();
        end
        check("faulted_skipped", 32'(seen), 32'd0);
        check("faulted_idle", 32'(busy), 32'h0);
        clr_fault = 4'b0100;
        tick();
        clr_fault = 4'b0000;
        check("fault_cleared", 32'(fault), 32'h0);

        // Filled on the timeout edge -> normal release; clear vs timeout -> set wins
        do_reset();
        req = 4'b0100;
        tick();
        tick(199);
        filled = 4'b0100;
        tick();
        check("sim_release", 32'(grant), 32'h0);
        check("sim_no_fault", 32'(fault), 32'h0);
        filled = 4'b0000;
        wait_grant(idx, zeros);
        check("sim_regrant", 32'(idx), 32'd2);
        tick(199);
        clr_fault = 4'b0100;
        tick();
        clr_fault = 4'b0000;
        check("set_wins_fault", 32'(fault), 32'h4);
        check("set_wins_release", 32'(grant), 32'h0);

        // Asynchronous reset mid-grant
        do_reset();
        req = 4'b0001;
        tick(3);
        check("async_pre_grant", 32'(grant), 32'h1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_grant_drop", 32'(grant), 32'h0);
        check("async_busy_drop",  32'(busy),  32'h0);
        tick(2);
        req = 4'b1010;
        rst = 1'b1;
        tick();
        check("async_restart", 32'(grant), 32'h2);

        // Request withdrawal mid-grant
        do_reset();
        req = 4'b0010;
        tick(4);
        check("withdraw_pre", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();
        check("withdraw_release", 32'(grant), 32'h0);
        check("withdraw_gap_busy", 32'(busy), 32'h1);
        check("withdraw_no_fault", 32'(fault), 32'h0);
        req = 4'b0110;
        tick(2);
        check("withdraw_rr_ptr2", 32'(grant), 32'h4);
        req = 4'b0000;
        tick(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/water_inlet_arbiter.md
WATER_INLET_ARBITER -- requirements
Module: water_inlet_arbiter

Interface
REQ-001 Parameter: FILL_TIMEOUT, default 200, maximum grant length in cycles; legal range 2..255.
REQ-002 Parameter: GAP_CYCLES, default 2, idle cycles after each release so the valve can close; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 Port: req  input  4  per-washer fill request, driven from each washer's fillvalve_on.
REQ-006 Port: filled  input  4  per-washer water-level-reached sensor.
REQ-007 Port: clr_fault  input  4  per-washer fault clear, level-sensitive.
REQ-008 Port: grant  output  4  one-hot or zero; opens the shared mains valve toward that washer.
REQ-009 Port: busy  output  1  high whenever the state is not IDLE.
REQ-010 Port: fault  output  4  sticky per-washer fill-timeout flag.

Function
REQ-011 FSM states SHALL be IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-012 Eligible set SHALL be req & ~fault; a faulted washer is never granted until cleared.
REQ-013 In IDLE with a non-empty eligible set, the arbiter SHALL pick the first eligible index searching upward (mod 4) from rr_ptr.
REQ-014 It SHALL then enter GRANT and assert the matching grant bit on that same edge; grant is visible the cycle after req is sampled.
REQ-015 A request whose filled bit is already high SHALL still be granted; it releases one cycle later.
REQ-016 In GRANT, an 8-bit counter SHALL start at 0 and increment every cycle.
REQ-017 GRANT SHALL release (grant to 0, enter GAP) on the first edge where filled[g]=1 or req[g]=0.
REQ-018 GRANT SHALL also release when the counter equals FILL_TIMEOUT-1, setting fault[g] on that edge.
REQ-019 If filled[g]=1 and the timeout occur on the same edge, release SHALL be normal with no fault set.
REQ-020 On every release, rr_ptr SHALL become (g+1) mod 4.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles with grant=0, then return to IDLE; requests in GAP are held pending, not lost.
REQ-022 At most one grant bit SHALL ever be high, and at least GAP_CYCLES zero cycles SHALL separate any two grants.
REQ-023 fault[i] SHALL clear on the edge where clr_fault[i]=1, except that a same-edge timeout on i sets it (set wins).
REQ-024 clr_fault SHALL have no effect on the FSM, grant or rr_ptr.
REQ-025 Request changes on non-granted indices during GRANT SHALL not affect the current grant.

Reset
REQ-026 While rst=0: state=IDLE, grant=0000, busy=0, fault=0000, rr_ptr=0, counter=0.
REQ-027 Reset asserted mid-GRANT SHALL drop grant within the same cycle without waiting for a clock edge.
REQ-028 After rst returns high, arbitration SHALL restart from index 0 on the first following edge.

Verification
REQ-029 Single request: reset, req=0001, filled[0] rises 10 cycles after grant -> grant=0001 for 11 cycles, then 0000 for 2 cycles, busy falls, fault=0000.
REQ-030 Round-robin: req=1111 held, each filled bit pulsed 3 cycles after its grant -> grant order 0001,0010,0100,1000,0001, with 2 zero cycles between grants.
REQ-031 Timeout: FILL_TIMEOUT=200, req=0100, filled never rises -> grant held exactly 200 cycles, fault=0100; index 2 is then skipped while req=0100 stays high.
REQ-032 Simultaneous: filled[g] rises on the timeout edge -> normal release, fault stays 0; clr_fault[2] asserted on a timeout edge of index 2 -> fault[2]=1.
REQ-033 Async reset: rst pulled low mid-grant between edges -> grant=0000 and busy=0 before the next edge; after release, req=1010 -> grant=0010 first.
REQ-034 Request withdrawal: req[1] dropped mid-grant -> grant falls on the next edge, GAP entered, rr_ptr=2, no fault.
